// File: rtl/gpp_top.sv
// gpp_top: multicycle 32-bit MIPS-subset processor.
// It contains a host-loadable instruction cache, a data memory and a 32-entry register file.
//
// Ports:
//   Clk     rising-edge clock for all state
//   Rst     async active-high core reset (PC, registers, Done; state -> S_INIT)
//   Rst_M   async active-high memory reset (I-cache, DM, Data_O; state -> S_IDLE)
//   Done    program-finished flag (registered, held in S_DONE)
//   Addr    host I-cache word address
//   Data_I  host write data
//   Data_O  host read data (one-cycle latency, holds when En=0)
//   En      host access enable
//   RW      1 = write, 0 = read
//
// Optional feature: define GPP_BNE_EN to decode opcode 0x05 as BNE.
// When it is not defined, that opcode is a NOP.
module gpp_top #(
    parameter int unsigned SA_WIDTH = 6,
    parameter int unsigned D_WIDTH  = 32,
    parameter int unsigned SL_WIDTH = 64,
    parameter int unsigned DM_DEPTH = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Rst_M,
    output logic                Done,
    input  logic [SA_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0]  Data_I,
    output logic [D_WIDTH-1:0]  Data_O,
    input  logic                En,
    input  logic                RW
);

    localparam int unsigned DM_AW    = $clog2(DM_DEPTH);
    localparam int unsigned RF_DEPTH = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef GPP_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [D_WIDTH-1:0]  icache [SL_WIDTH];
    logic [D_WIDTH-1:0]  dm     [DM_DEPTH];
    logic [D_WIDTH-1:0]  rf     [RF_DEPTH];

    logic [SA_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0]  ir;
    logic [D_WIDTH-1:0]  a_q;
    logic [D_WIDTH-1:0]  b_q;
    logic [D_WIDTH-1:0]  imm_q;
    logic [D_WIDTH-1:0]  alu_q;
    logic [D_WIDTH-1:0]  mdr_q;

    // Instruction fields; IR is stable from DECODE through WB.
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [D_WIDTH-1:0] imm_sx;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_sx = {{(D_WIDTH-16){ir[15]}}, ir[15:0]};

    logic is_halt, is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, funct_ok;

    assign is_halt  = &ir;
    assign is_rtype = (op == OP_RTYPE);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
`ifdef GPP_BNE_EN
    assign is_bne   = (op == OP_BNE);
`else
    assign is_bne   = 1'b0;
`endif

    // ALU; unknown functs yield 0 and are never written back.
    logic [D_WIDTH-1:0] alu_c;
    logic               slt_c;

    always_comb begin
        alu_c = '0;
        slt_c = ($signed(a_q) < $signed(b_q));
        if (is_rtype) begin
            case (funct)
                FN_ADD:  alu_c = a_q + b_q;
                FN_SUB:  alu_c = a_q - b_q;
                FN_AND:  alu_c = a_q & b_q;
                FN_OR:   alu_c = a_q | b_q;
                FN_SLT:  alu_c = D_WIDTH'(slt_c);
                default: alu_c = '0;
            endcase
        end else if (is_addi || is_lw || is_sw) begin
            alu_c = a_q + imm_q;
        end
    end

    // Branch resolution and PC arithmetic, both modulo the I-cache size.
    logic                is_branch_c;
    logic                take_c;
    logic [SA_WIDTH-1:0] pc_inc_c;
    logic [SA_WIDTH-1:0] pc_tgt_c;

    assign is_branch_c = is_beq || is_bne;
    assign take_c      = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    assign pc_inc_c    = pc + SA_WIDTH'(1);
    assign pc_tgt_c    = pc_inc_c + imm_q[SA_WIDTH-1:0];

    // Write-back selection; writes to $0 are dropped.
    logic               wb_en_c;
    logic [4:0]         wb_idx_c;
    logic [D_WIDTH-1:0] wb_data_c;

    assign wb_en_c   = ((is_rtype && funct_ok) || is_addi || is_lw) && (wb_idx_c != 5'd0);
    assign wb_idx_c  = is_rtype ? rd : rt;
    assign wb_data_c = is_lw ? mdr_q : alu_q;

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   state_d = S_IDLE;
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_halt)   state_d = S_DONE;
                else if (is_j) state_d = S_FETCH;
                else           state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch_c)        state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:    state_d = is_sw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; the memory reset parks the core in S_IDLE.
    always_ff @(posedge Clk or posedge Rst or posedge Rst_M) begin
        if (Rst_M)    state <= S_IDLE;
        else if (Rst) state <= S_INIT;
        else          state <= state_d;
    end

    // Core datapath registers, register file and Done.
    always_ff @(posedge Clk or posedge Rst or posedge Rst_M) begin
        if (Rst || Rst_M) begin
            pc    <= '0;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            Done  <= 1'b0;
            for (int i = 0; i < int'(RF_DEPTH); i++) rf[i] <= '0;
        end else begin
            Done <= (state_d == S_DONE);
            case (state)
                S_FETCH: ir <= icache[pc];
                S_DECODE: begin
                    a_q   <= rf[rs];
                    b_q   <= rf[rt];
                    imm_q <= imm_sx;
                    if (is_j && !is_halt) pc <= ir[SA_WIDTH-1:0];
                end
                S_EXEC: begin
                    alu_q <= alu_c;
                    if (is_branch_c) pc <= take_c ? pc_tgt_c : pc_inc_c;
                end
                S_MEM: begin
                    if (is_sw) pc <= pc_inc_c;
                    else       mdr_q <= dm[alu_q[DM_AW-1:0]];
                end
                S_WB: begin
                    if (wb_en_c) rf[wb_idx_c] <= wb_data_c;
                    pc <= pc_inc_c;
                end
                default: ;
            endcase
        end
    end

    // Data memory; the address wraps modulo DM_DEPTH.
    always_ff @(posedge Clk or posedge Rst_M) begin
        if (Rst_M) begin
            for (int i = 0; i < int'(DM_DEPTH); i++) dm[i] <= '0;
        end else if ((state == S_MEM) && is_sw) begin
            dm[alu_q[DM_AW-1:0]] <= b_q;
        end
    end

    // Host port into the I-cache. A fetch in the same cycle sees the old word.
    always_ff @(posedge Clk or posedge Rst_M) begin
        if (Rst_M) begin
            for (int i = 0; i < int'(SL_WIDTH); i++) icache[i] <= '0;
            Data_O <= '0;
        end else if (En) begin
            if (RW) icache[Addr] <= Data_I;
            else    Data_O <= icache[Addr];
        end
    end

endmodule

// File: tb/tb_gpp_top.sv
// tb_gpp_top: directed tests for gpp_top.
// It loads programs through the host port, runs them and checks the timing of Done.
// It also checks the architectural state against hand-computed values.
module tb_gpp_top;

    logic        Clk;
    logic        Rst;
    logic        Rst_M;
    logic        Done;
    logic [5:0]  Addr;
    logic [31:0] Data_I;
    logic [31:0] Data_O;
    logic        En;
    logic        RW;

    int n_vec = 0;
    int n_err = 0;

    gpp_top dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Rst_M  (Rst_M),
        .Done   (Done),
        .Addr   (Addr),
        .Data_I (Data_I),
        .Data_O (Data_O),
        .En     (En),
        .RW     (RW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic host_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge Clk); #1;
        En = 1'b1; RW = 1'b1; Addr = a; Data_I = d;
        @(posedge Clk); #1;
        En = 1'b0; RW = 1'b0;
    endtask

    task automatic host_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge Clk); #1;
        En = 1'b1; RW = 1'b0; Addr = a;
        @(posedge Clk); #1;
        En = 1'b0;
        d = Data_O;
    endtask

    task automatic load(input logic [31:0] p[$]);
        foreach (p[i]) host_write(6'(i), p[i]);
    endtask

    // Pulse Rst, then count edges until Done rises. The result is -1 on timeout.
    task automatic run_core(input int budget, output int cycles);
        @(posedge Clk); #1; Rst = 1'b1;
        @(posedge Clk); #1; Rst = 1'b0;
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Rst_M = 1'b1; Rst = 1'b0; En = 1'b0; RW = 1'b0; Addr = '0; Data_I = '0;
        repeat (2) @(posedge Clk);
        #1;
        n_vec++;
        if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", Done); end
        n_vec++;
        if (Data_O !== 32'h0) begin n_err++; $display("FAIL reset_data_o: got %h want 00000000", Data_O); end
        Rst_M = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        n_vec++;
        if (Done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", Done); end
        n_vec++;
        if (dut.pc !== 6'd0) begin n_err++; $display("FAIL idle_pc: got %0d want 0", dut.pc); end
    endtask

    task automatic test_load_readback;
        logic [31:0] d;
        host_write(6'd3, 32'h12345678);
        host_read(6'd4, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL read_unwritten: got %h want 00000000", d); end
        host_read(6'd3, d);
        n_vec++;
        if (d !== 32'h12345678) begin n_err++; $display("FAIL read_addr3: got %h want 12345678", d); end
        Addr = 6'd4;
        repeat (2) @(posedge Clk);
        #1;
        n_vec++;
        if (Data_O !== 32'h12345678) begin n_err++; $display("FAIL data_o_hold: got %h want 12345678", Data_O); end
    endtask

    task automatic test_halt;
        logic       exp_done [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] d;
        host_write(6'd0, 32'hFFFFFFFF);
        @(posedge Clk); #1; Rst = 1'b1;
        @(posedge Clk); #1; Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_vec++;
            if (Done !== exp_done[i]) begin
                n_err++;
                $display("FAIL halt_done_cyc%0d: got %b want %b", i + 1, Done, exp_done[i]);
            end
        end
        repeat (5) @(posedge Clk);
        #1;
        n_vec++;
        if (Done !== 1'b1) begin n_err++; $display("FAIL halt_done_held: got %b want 1", Done); end
        host_read(6'd0, d);
        n_vec++;
        if (d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL read_in_done: got %h want ffffffff", d); end
    endtask

    task automatic test_arith;
        logic [31:0] p[$];
        logic [31:0] exp_rf [6] = '{32'd0, 32'd5, 32'd7, 32'd12, 32'hFFFFFFFE, 32'd1};
        int cyc;
        p = '{32'h20010005,   // ADDI $1,$0,5
              32'h20020007,   // ADDI $2,$0,7
              32'h00221820,   // ADD  $3,$1,$2
              32'h00222022,   // SUB  $4,$1,$2
              32'h0080282A,   // SLT  $5,$4,$0
              32'hFFFFFFFF};  // HALT
        load(p);
        run_core(200, cyc);
        n_vec++;
        if (cyc !== 23) begin n_err++; $display("FAIL arith_cycles: got %0d want 23", cyc); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (dut.rf[i] !== exp_rf[i]) begin
                n_err++;
                $display("FAIL arith_r%0d: got %h want %h", i, dut.rf[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_mem_branch;
        logic [31:0] p[$];
        int          ridx [5] = '{0, 6, 7, 8, 3};
        logic [31:0] rexp [5] = '{32'd0, 32'd12, 32'd0, 32'd3, 32'd12};
        int cyc;
        p = '{32'h20010005,   // 0  ADDI $1,$0,5
              32'h2003000C,   // 1  ADDI $3,$0,12
              32'hAC030002,   // 2  SW   $3,2($0)
              32'h8C060002,   // 3  LW   $6,2($0)
              32'h10C30001,   // 4  BEQ  $6,$3,+1 (taken)
              32'h20070063,   // 5  ADDI $7,$0,99 (skipped)
              32'h20000009,   // 6  ADDI $0,$0,9 (discarded)
              32'hAC010013,   // 7  SW   $1,19($0) -> DM[3]
              32'h0800000A,   // 8  J    10
              32'h20070001,   // 9  ADDI $7,$0,1 (skipped)
              32'h10230001,   // 10 BEQ  $1,$3,+1 (not taken)
              32'h20080003,   // 11 ADDI $8,$0,3
              32'hFFFFFFFF};  // 12 HALT
        load(p);
        run_core(200, cyc);
        n_vec++;
        if (cyc !== 40) begin n_err++; $display("FAIL memb_cycles: got %0d want 40", cyc); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut.rf[ridx[i]] !== rexp[i]) begin
                n_err++;
                $display("FAIL memb_r%0d: got %h want %h", ridx[i], dut.rf[ridx[i]], rexp[i]);
            end
        end
        n_vec++;
        if (dut.dm[2] !== 32'd12) begin n_err++; $display("FAIL memb_dm2: got %h want 0000000c", dut.dm[2]); end
        n_vec++;
        if (dut.dm[3] !== 32'd5) begin n_err++; $display("FAIL memb_dm3_wrap: got %h want 00000005", dut.dm[3]); end
    endtask

    task automatic test_pc_wrap;
        int cyc;
        host_write(6'd0, 32'h10200001);   // BEQ $1,$0,+1
        host_write(6'd1, 32'hFFFFFFFF);   // HALT
        host_write(6'd2, 32'h0800003F);   // J 63
        host_write(6'd63, 32'h20010004);  // ADDI $1,$0,4, then PC wraps to 0
        run_core(200, cyc);
        n_vec++;
        if (cyc !== 15) begin n_err++; $display("FAIL wrap_cycles: got %0d want 15", cyc); end
        n_vec++;
        if (dut.rf[1] !== 32'd4) begin n_err++; $display("FAIL wrap_r1: got %h want 00000004", dut.rf[1]); end
    endtask

    task automatic test_bne;
        logic [31:0] p[$];
        int cyc;
        int exp_cyc;
        logic [31:0] exp_r9;
`ifdef GPP_BNE_EN
        exp_cyc = 22; exp_r9 = 32'd0;
`else
        exp_cyc = 27; exp_r9 = 32'd1;
`endif
        p = '{32'h20010005,   // ADDI $1,$0,5
              32'h20020007,   // ADDI $2,$0,7
              32'h14220001,   // BNE  $1,$2,+1 (or NOP)
              32'h20090001,   // ADDI $9,$0,1
              32'h200A0002,   // ADDI $10,$0,2
              32'h0022583F,   // R-type unknown funct -> NOP
              32'hFFFFFFFF};  // HALT
        load(p);
        run_core(200, cyc);
        n_vec++;
        if (cyc !== exp_cyc) begin n_err++; $display("FAIL bne_cycles: got %0d want %0d", cyc, exp_cyc); end
        n_vec++;
        if (dut.rf[9] !== exp_r9) begin n_err++; $display("FAIL bne_r9: got %h want %h", dut.rf[9], exp_r9); end
        n_vec++;
        if (dut.rf[10] !== 32'd2) begin n_err++; $display("FAIL bne_r10: got %h want 00000002", dut.rf[10]); end
        n_vec++;
        if (dut.rf[11] !== 32'd0) begin n_err++; $display("FAIL bad_funct_r11: got %h want 00000000", dut.rf[11]); end
    endtask

    task automatic test_reset_midrun;
        host_write(6'd0, 32'h20210001);   // ADDI $1,$1,1
        host_write(6'd1, 32'h08000000);   // J 0
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge Clk); #1; Rst = 1'b1;
            @(posedge Clk); #1; Rst = 1'b0;
            // The edge-15 state is EXEC of the third ADDI, after two completed increments.
            repeat (15) @(posedge Clk);
            #1;
            n_vec++;
            if (dut.rf[1] !== 32'd2) begin n_err++; $display("FAIL midrun_r1_pass%0d: got %h want 00000002", pass, dut.rf[1]); end
            n_vec++;
            if (Done !== 1'b0) begin n_err++; $display("FAIL midrun_done_pass%0d: got %b want 0", pass, Done); end
            Rst = 1'b1;
            #1;
            n_vec++;
            if (dut.pc !== 6'd0) begin n_err++; $display("FAIL midrun_pc_pass%0d: got %0d want 0", pass, dut.pc); end
            n_vec++;
            if (dut.rf[1] !== 32'd0) begin n_err++; $display("FAIL midrun_rst_r1_pass%0d: got %h want 00000000", pass, dut.rf[1]); end
            @(posedge Clk); #1; Rst = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_load_readback;
        test_halt;
        test_arith;
        test_mem_branch;
        test_pc_wrap;
        test_bne;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpp_top.md
Name: gpp_top

Overview:
- Top of a small 32-bit multicycle MIPS-subset general-purpose processor with an internal instruction cache (SRAM), data memory and register file.
- The host loads the program through a word-wide SRAM port, pulses reset, then waits for the Done flag.
- Sits directly under the system bench/host as the complete compute block.

Parameters:
- SA_WIDTH, 6: instruction-cache address width (word index); also PC width.
- D_WIDTH, 32: data/instruction word width.
- SL_WIDTH, 64: number of instruction-cache lines (2**SA_WIDTH).
- DM_DEPTH, 16: data-memory words.

Ports:
- Clk  in  1  single clock, all state on rising edge.
- Rst  in  1  asynchronous, active-high core reset.
- Rst_M  in  1  asynchronous, active-high memory reset.
- Done  out  1  program finished flag.
- Addr  in  SA_WIDTH  host I-cache word address.
- Data_I  in  D_WIDTH  host write data.
- Data_O  out  D_WIDTH  host read data.
- En  in  1  host access enable.
- RW  in  1  1 = write, 0 = read.

Behaviour:
- Reset model: one clock; resets asynchronous and active-high.
- Rst_M:
  - Clears all I-cache lines, data memory and Data_O to 0.
  - Forces core state to S_IDLE with Done=0.
- Rst:
  - Sets PC=0, all 32 registers=0, Done=0, state=S_INIT.
  - Does not touch I-cache contents.
- Host port (honoured in every core state):
  - En=1, RW=1: I-cache[Addr] <= Data_I on the clock edge.
  - En=1, RW=0: Data_O <= I-cache[Addr], one-cycle latency.
  - En=0: Data_O holds its value.
  - Host write and core fetch of the same line in one cycle: the fetch returns the old word.
- Core FSM states: S_IDLE, S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE.
  - S_IDLE: stays there until Rst is asserted.
  - S_INIT -> S_FETCH, unconditional.
  - S_FETCH: IR <= I-cache[PC] (combinational read port).
  - S_DECODE: reads rs/rt, sign-extends imm16.
    - IR == 32'hFFFFFFFF (HALT) -> S_DONE.
    - J: PC <= IR[SA_WIDTH-1:0] -> S_FETCH.
    - Otherwise -> S_EXEC.
  - S_EXEC: ALU operation.
    - BEQ: if rs==rt then PC <= PC+1+imm, else PC <= PC+1; -> S_FETCH.
    - LW/SW -> S_MEM.
    - Others -> S_WB.
  - S_MEM:
    - SW: DM[(rs+imm) mod DM_DEPTH] <= rt; PC <= PC+1 -> S_FETCH.
    - LW -> S_WB.
  - S_WB: write the result to rd (R-type) or rt (ADDI/LW); PC <= PC+1 -> S_FETCH.
  - S_DONE: Done=1, held until Rst or Rst_M.
- Instruction set:
  - R-type (op 0x00), funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - Unknown opcode or funct: NOP, i.e. PC+1 through S_WB with no register write.
- Arithmetic rules:
  - Wrap modulo 2^32; no overflow traps.
  - Writes to $0 are discarded; $0 always reads 0.
  - PC arithmetic is modulo SL_WIDTH; wrap from 63 to 0 is legal.
- Latency in cycles from S_FETCH: R/ADDI 4, LW 5, SW 4, BEQ 3, J 2, HALT 2 to Done.
- Rst asserted mid-program: immediate return to S_INIT and restart at PC=0 with the same I-cache contents.

Optional Feature:
- Macro GPP_BNE_EN.
- Defined: opcode 0x05 is BNE; S_EXEC takes the branch when rs!=rt, same timing as BEQ.
- Undefined: opcode 0x05 decodes as NOP.

Test Plan:
- Load and readback:
  - Rst_M pulse, then write 0x12345678 to Addr 3.
  - Read Addr 3 -> Data_O=0x12345678 one cycle later; unwritten Addr 4 -> 0.
- Immediate halt:
  - Line 0 = FFFFFFFF; pulse Rst -> Done=1 exactly 3 cycles after Rst falls (INIT, FETCH, DECODE), and stays 1.
- Arithmetic program:
  - ADDI $1,$0,5; ADDI $2,$0,7; ADD $3,$1,$2; SUB $4,$1,$2; SLT $5,$4,$0; HALT.
  - Result: $3=12, $4=0xFFFFFFFE, $5=1; Done asserted.
- Memory and branch:
  - SW $3 to DM[2], LW $6 from DM[2] -> $6=12.
  - BEQ $6,$3,+1 skips the next ADDI; J to HALT line -> Done.
- Reset mid-run:
  - Assert Rst while in S_EXEC of a looping program -> PC=0, registers 0, Done=0.
  - Re-run produces the same results.
- With GPP_BNE_EN:
  - BNE $1,$2,+1 with 5!=7 branches.
  - Without the macro, the same word acts as a NOP.
